// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller:
// controller state encoding, forwarding mux selects and register index width.
package pipe_pkg;

    // Register file index width (x0..x31).
    localparam int REG_AW = 5;

    // Forwarding mux selects in front of the ALU operands.
    localparam logic [1:0] FWD_RF = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_W  = 2'b01;  // result being written back in W
    localparam logic [1:0] FWD_M  = 2'b10;  // ALU result sitting in M

    // Controller sequencing states.
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Ports: clk, rst (sync, active high), inc (count enable), count (value).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = (count == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: ALU forwarding,
// load-use stall, branch flush, memory-wait freeze, timeout halt, event counters.
// Ports: clk/rst; Decode/Execute/Memory/Writeback register indices and enables;
// LoadE, PCSrcE, MemReqM, MemReadyM in; forwarding selects, stalls, flushes,
// MemErr and the two saturating counters out.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     Rs1E,
    input  logic [REG_AW-1:0]     Rs2E,
    input  logic [REG_AW-1:0]     RdE,
    input  logic [REG_AW-1:0]     RdM,
    input  logic [REG_AW-1:0]     RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr,
    output logic [DATA_WIDTH-1:0] StallCount,
    output logic [DATA_WIDTH-1:0] FlushCount
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1) + 1;

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

    hz_state_t     state;
    logic [IW-1:0] init_cnt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          mem_err;

    logic          lw_stall;
    logic          mem_busy;
    logic          hold;
    logic          stall_ev;
    logic          flush_ev;

    // Hazard detection terms
    assign lw_stall = LoadE && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_busy = MemReqM && !MemReadyM;
    assign wait_nxt = wait_cnt + WW'(1);

    // Whole pipeline frozen: memory busy in RUN, still waiting, or halted.
    always_comb begin
        hold = 1'b0;
        unique case (state)
            INIT:     hold = 1'b0;
            RUN:      hold = mem_busy;
            MEM_WAIT: hold = !MemReadyM;
            HALT:     hold = 1'b1;
        endcase
    end

    // Forwarding: M has priority over W as it holds the younger result.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (state != INIT) begin
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
                ForwardAE = FWD_M;
            end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
                ForwardAE = FWD_W;
            end
            if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
                ForwardBE = FWD_M;
            end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
                ForwardBE = FWD_W;
            end
        end
    end

    // Stall and flush controls
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (state == INIT) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (hold) begin
            // Branch and load-use effects are masked while frozen.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    assign MemErr = mem_err;

    // Sequencing FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state <= RUN;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt >= WAIT_MAX) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Performance events are not counted during the post-reset flush.
    assign stall_ev = (state != INIT) && StallF;
    assign flush_ev = (state != INIT) && (FlushD || FlushE);

    sat_counter #(
        .WIDTH(DATA_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_ev),
        .count(StallCount)
    );

    sat_counter #(
        .WIDTH(DATA_WIDTH)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush_ev),
        .count(FlushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int DW  = 8;
    localparam int IC  = 2;
    localparam int TO  = 4;
    localparam int MAXC = (1 << DW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, MemErr;
    logic [DW-1:0] StallCount, FlushCount;

    hazard_ctrl #(
        .DATA_WIDTH (DW),
        .INIT_CYCLES(IC),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model state: cycles since reset, consecutive frozen cycles, halt flag.
    bit armed     = 1'b0;
    int since_rst = 0;
    int busy_run  = 0;
    bit halted    = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic sF, sD, sE, sM, fD, fE, fW, er;
    } exp_t;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit frozen, lw;
        e = '0;
        if (since_rst < IC) begin
            e.sF = 1; e.fD = 1; e.fE = 1; e.fW = 1;
        end else begin
            e.fa = fwd(Rs1E);
            e.fb = fwd(Rs2E);
            if (halted) frozen = 1;
            else if (busy_run > 0) frozen = !MemReadyM;
            else frozen = MemReqM && !MemReadyM;
            lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (frozen) begin
                e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fW = 1;
            end else begin
                e.sF = lw; e.sD = lw; e.fD = PCSrcE; e.fE = lw || PCSrcE;
            end
            e.er = halted;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model_out();
        if (rst) begin
            armed = 1; since_rst = 0; busy_run = 0; halted = 0;
            m_stall = 0; m_flush = 0;
        end else if (armed) begin
            if (since_rst < IC) begin
                since_rst++;
            end else begin
                if (e.sF && m_stall < MAXC) m_stall++;
                if ((e.fD || e.fE) && m_flush < MAXC) m_flush++;
                if (!halted) begin
                    if (e.sM) begin
                        busy_run++;
                        if (busy_run >= TO) halted = 1;
                    end else begin
                        busy_run = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (armed) begin
            e = model_out();
            a = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, MemErr};
            n_chk++;
            if (a === e && StallCount === DW'(m_stall) &&
                FlushCount === DW'(m_flush)) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t ctl got %h exp %h sc got %0d exp %0d fc got %0d exp %0d",
                         $time, a, e, StallCount, m_stall, FlushCount, m_flush);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // post-reset flush window
        @(negedge clk);
        chk("init1_stallf", StallF, 1);
        chk("init1_flushd", FlushD, 1);
        @(negedge clk);
        chk("init2_flushe", FlushE, 1);
        @(negedge clk);
        chk("run_flushd", FlushD, 0);
        chk("run_stallf", StallF, 0);
        chk("stallcnt0", StallCount, 0);
        chk("flushcnt0", FlushCount, 0);

        // forwarding priority
        step();
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
        @(negedge clk);
        chk("fwd_m", ForwardAE, 2'b10);
        #1 RdM = 0;
        #1 chk("fwd_w", ForwardAE, 2'b01);
        step();
        idle();

        // load-use
        LoadE = 1; RdE = 7; Rs2D = 7;
        @(negedge clk);
        chk("lu_stallf", StallF, 1);
        chk("lu_stalld", StallD, 1);
        chk("lu_flushe", FlushE, 1);
        step();
        idle();
        @(negedge clk);
        chk("lu_release", StallF, 0);
        chk("lu_stallcnt", StallCount, 1);

        // branch
        step();
        PCSrcE = 1;
        @(negedge clk);
        chk("br_flushd", FlushD, 1);
        chk("br_flushe", FlushE, 1);
        step();
        PCSrcE = 0;
        @(negedge clk);
        chk("br_once", FlushD, 0);
        chk("br_flushcnt", FlushCount, 2);

        // memory wait of three cycles
        step();
        MemReqM = 1; MemReadyM = 0;
        @(negedge clk);
        chk("mw1_stallm", StallM, 1);
        chk("mw1_flushw", FlushW, 1);
        step();
        PCSrcE = 1;
        @(negedge clk);
        chk("mw2_noflush", FlushD, 0);
        chk("mw2_stalld", StallD, 1);
        step();
        PCSrcE = 0;
        @(negedge clk);
        chk("mw3_stalle", StallE, 1);
        step();
        MemReadyM = 1;
        @(negedge clk);
        chk("mw_rel_stallf", StallF, 0);
        chk("mw_rel_flushw", FlushW, 0);
        step();
        MemReqM = 0; MemReadyM = 0;
        @(negedge clk);
        chk("mw_stallcnt", StallCount, 4);

        // timeout into HALT
        step();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("to_pre_err", MemErr, 0);
            step();
        end
        @(negedge clk);
        chk("to_err", MemErr, 1);
        chk("to_stallf", StallF, 1);
        MemReqM = 0; MemReadyM = 1;
        repeat (300) step();
        @(negedge clk);
        chk("halt_sticky", MemErr, 1);
        chk("stallcnt_sat", StallCount, MAXC);
        chk("halt_flushcnt", FlushCount, 2);

        // reset while halted
        step();
        rst = 1;
        step();
        rst = 0;
        idle();
        @(negedge clk);
        chk("rst_err", MemErr, 0);
        chk("rst_init", FlushD, 1);
        chk("rst_cnt", StallCount, 0);

        // randomized traffic
        repeat (4000) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            Rs1D      = 5'($urandom_range(0, 3));
            Rs2D      = 5'($urandom_range(0, 3));
            Rs1E      = 5'($urandom_range(0, 3));
            Rs2E      = 5'($urandom_range(0, 3));
            RdE       = 5'($urandom_range(0, 3));
            RdM       = 5'($urandom_range(0, 3));
            RdW       = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            LoadE     = ($urandom_range(0, 2) == 0);
            PCSrcE    = ($urandom_range(0, 4) == 0);
            MemReqM   = ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 9) < 6);
        end
        step();
        rst = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
